// File: rtl/mpsoc_uart_rx.sv
// mpsoc_uart_rx: UART receive engine. It recovers 5-8 bit frames with optional
// even parity and 1 or 2 stop bits, and presents each character on a
// valid/ready handshake with one-cycle error pulses.
// Optional build macro MPSOC_UART_RX_MAJORITY_EN selects a 2-of-3 majority
// vote around every sample point instead of a single sample.
module mpsoc_uart_rx #(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic        rx_i,
  output logic        busy_o,
  input  logic        cfg_en_i,
  input  logic [15:0] cfg_div_i,
  input  logic        cfg_parity_en_i,
  input  logic [1:0]  cfg_bits_i,
  input  logic        cfg_stop_bits_i,
  output logic [7:0]  rx_data_o,
  output logic        rx_valid_o,
  input  logic        rx_ready_i,
  output logic        err_parity_o,
  output logic        err_frame_o,
  output logic        err_overrun_o
);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP1, STOP2} state_e;

  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   rx_dly_q, rx_dly_d;
  logic [15:0]            cnt_q, cnt_d;
  logic [2:0]             bit_q, bit_d;
  logic [7:0]             shreg_q, shreg_d;
  logic                   par_q, par_d;
  logic                   perr_q, perr_d;
  logic                   ferr_q, ferr_d;
  logic                   done_q, done_d;
  logic [7:0]             data_q, data_d;
  logic                   valid_q, valid_d;
  logic                   err_p_q, err_p_d;
  logic                   err_f_q, err_f_d;
  logic                   err_o_q, err_o_d;

  logic       rx_s, line, line_prev, samp;
  logic       at_half, at_full;
  logic [2:0] last_bit;

  assign rx_s     = sync_q[SYNC_STAGES-1];
  assign at_full  = (cnt_q == cfg_div_i);
  assign at_half  = (cnt_q == {1'b0, cfg_div_i[15:1]});
  assign last_bit = 3'd4 + {1'b0, cfg_bits_i};

`ifdef MPSOC_UART_RX_MAJORITY_EN
  logic rx_dly2_q;

  // Second delay tap so the vote window point-1/point/point+1 is available.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) rx_dly2_q <= 1'b1;
    else         rx_dly2_q <= rx_dly_q;
  end

  // The receiver works on the line one cycle late so that the vote is
  // centred on the sample point and frame timing stays unchanged.
  assign line      = rx_dly_q;
  assign line_prev = rx_dly2_q;
  assign samp      = (rx_dly2_q & rx_dly_q) | (rx_dly2_q & rx_s) | (rx_dly_q & rx_s);
`else
  assign line      = rx_s;
  assign line_prev = rx_dly_q;
  assign samp      = rx_s;
`endif

  // Synchroniser shift and one-cycle delayed copy for edge detection.
  always_comb begin
    sync_d   = {sync_q[SYNC_STAGES-2:0], rx_i};
    rx_dly_d = rx_s;
  end

  // Frame FSM: start detection, bit sampling, parity and stop checks.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    par_d   = par_q;
    perr_d  = perr_q;
    ferr_d  = ferr_q;
    done_d  = 1'b0;
    if (state_q != IDLE) cnt_d = at_full ? 16'd0 : cnt_q + 16'd1;
    if (!cfg_en_i) begin
      state_d = IDLE;
      cnt_d   = 16'd0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (line_prev && !line) begin
            state_d = START;
            cnt_d   = 16'd0;
            bit_d   = 3'd0;
            shreg_d = 8'd0;
            par_d   = 1'b0;
            perr_d  = 1'b0;
            ferr_d  = 1'b0;
          end
        end
        START: begin
          if (at_half) begin
            cnt_d   = 16'd0;
            state_d = samp ? IDLE : DATA;
          end
        end
        DATA: begin
          if (at_full) begin
            shreg_d[bit_q] = samp;
            par_d          = par_q ^ samp;
            bit_d          = bit_q + 3'd1;
            if (bit_q == last_bit) state_d = cfg_parity_en_i ? PARITY : STOP1;
          end
        end
        PARITY: begin
          if (at_full) begin
            perr_d  = (samp != par_q);
            state_d = STOP1;
          end
        end
        STOP1: begin
          if (at_full) begin
            if (!samp) ferr_d = 1'b1;
            if (cfg_stop_bits_i) begin
              state_d = STOP2;
            end else begin
              state_d = IDLE;
              done_d  = 1'b1;
            end
          end
        end
        STOP2: begin
          if (at_full) begin
            if (!samp) ferr_d = 1'b1;
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Completion and handshake: deliver, flag overrun, or clear on accept.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    err_p_d = 1'b0;
    err_f_d = 1'b0;
    err_o_d = 1'b0;
    if (done_q && (!valid_q || rx_ready_i)) begin
      data_d  = shreg_q;
      valid_d = 1'b1;
      err_p_d = perr_q;
      err_f_d = ferr_q;
    end else if (done_q) begin
      err_o_d = 1'b1;
    end else if (valid_q && rx_ready_i) begin
      valid_d = 1'b0;
    end
  end

  // State and output registers.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      sync_q   <= '1;
      rx_dly_q <= 1'b1;
      state_q  <= IDLE;
      cnt_q    <= 16'd0;
      bit_q    <= 3'd0;
      shreg_q  <= 8'd0;
      par_q    <= 1'b0;
      perr_q   <= 1'b0;
      ferr_q   <= 1'b0;
      done_q   <= 1'b0;
      data_q   <= 8'd0;
      valid_q  <= 1'b0;
      err_p_q  <= 1'b0;
      err_f_q  <= 1'b0;
      err_o_q  <= 1'b0;
    end else begin
      sync_q   <= sync_d;
      rx_dly_q <= rx_dly_d;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      shreg_q  <= shreg_d;
      par_q    <= par_d;
      perr_q   <= perr_d;
      ferr_q   <= ferr_d;
      done_q   <= done_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      err_p_q  <= err_p_d;
      err_f_q  <= err_f_d;
      err_o_q  <= err_o_d;
    end
  end

  assign busy_o        = (state_q != IDLE);
  assign rx_data_o     = data_q;
  assign rx_valid_o    = valid_q;
  assign err_parity_o  = err_p_q;
  assign err_frame_o   = err_f_q;
  assign err_overrun_o = err_o_q;

endmodule

// File: doc/mpsoc_uart_rx.md
Name: mpsoc_uart_rx

Overview:
- UART receive engine; downstream peer of the UART transmitter across the serial line.
- Recovers frames from the asynchronous rx_i line and presents each received character on a valid/ready handshake to the APB register/FIFO layer.
- Frame format is programmed with the same configuration fields as the transmitter:
  - divider,
  - 5-8 data bits,
  - optional even parity,
  - 1 or 2 stop bits.

Parameters:
- SYNC_STAGES, 2, number of flip-flops in the rx_i synchroniser (minimum 2).

Ports:
- clk_i  in  1  core clock
- rstn_i  in  1  reset; asynchronous, active-low
- rx_i  in  1  serial input, asynchronous, idle high
- busy_o  out  1  high while a frame is being received (state != IDLE)
- cfg_en_i  in  1  receiver enable
- cfg_div_i  in  16  bit period = cfg_div_i+1 clocks
- cfg_parity_en_i  in  1  even parity bit present after data
- cfg_bits_i  in  2  data bits: 00=5, 01=6, 10=7, 11=8
- cfg_stop_bits_i  in  1  0=one stop bit, 1=two stop bits
- rx_data_o  out  8  received character, LSB-aligned, unused upper bits 0
- rx_valid_o  out  1  rx_data_o valid
- rx_ready_i  in  1  consumer accepts rx_data_o
- err_parity_o  out  1  one-cycle pulse: parity mismatch
- err_frame_o  out  1  one-cycle pulse: stop bit sampled low
- err_overrun_o  out  1  one-cycle pulse: frame completed while rx_valid_o still high

Behaviour:
- Reset values:
  - rx_data_o=0, rx_valid_o=0, busy_o=0, all err_*=0.
  - State IDLE, baud counter 0.
  - Synchroniser flops preset to 1.
- Input path: rx_i passes through SYNC_STAGES flops, giving rx_s. All logic uses rx_s plus a one-cycle-delayed copy rx_d.
- Baud counter:
  - Counts 0..cfg_div_i while busy; wraps to 0.
  - Held at 0 in IDLE.
  - Half point is cfg_div_i>>1.
- States: IDLE, START, DATA, PARITY, STOP1, STOP2.
- IDLE: when cfg_en_i=1 and rx_d=1 and rx_s=0 (falling edge), go to START with counter 0.
- START:
  - At counter==cfg_div_i>>1, sample.
  - If the sample is 1: false start, return to IDLE, no flags.
  - If the sample is 0: restart the counter and go to DATA.
- DATA:
  - At counter==cfg_div_i (one full period after the previous mid-point), shift the sample in LSB-first and XOR it into the parity accumulator.
  - After the Nth bit (N from cfg_bits_i): go to PARITY if cfg_parity_en_i, else STOP1.
- PARITY: at the full-period point, mismatch is flagged if sample != XOR of the data bits (even parity, matching the transmitter).
- STOP1:
  - At the full-period point, sample; 0 means framing error.
  - Then go to STOP2 if cfg_stop_bits_i, else complete.
- STOP2: same check, then complete.
- Completion (cycle after the final stop sample):
  - If rx_valid_o=0: load rx_data_o, set rx_valid_o, and pulse err_parity_o/err_frame_o as detected in the same cycle. Erroneous frames are still delivered.
  - If rx_valid_o=1 and rx_ready_i=0: drop the new frame, pulse err_overrun_o, rx_data_o unchanged.
  - If rx_valid_o=1 and rx_ready_i=1 in the completion cycle: accept the new frame, no overrun.
  - Return to IDLE. A falling edge in that same cycle starts a new frame immediately.
- Handshake: rx_valid_o clears on the cycle after rx_valid_o&&rx_ready_i unless a new frame loads in that cycle.
- Configuration: cfg_* must be stable while busy_o=1; they are sampled live, with no latching.
- cfg_en_i=0:
  - Forces IDLE next cycle; any in-progress frame is discarded without flags.
  - rx_valid_o/rx_data_o are unaffected.
- Reset mid-frame: everything returns to reset values immediately.
- Minimum supported cfg_div_i is 3; behaviour below that is undefined.

Optional Feature:
- Macro: MPSOC_UART_RX_MAJORITY_EN.
- Defined:
  - Each sample point (start, data, parity, stop) uses a 2-of-3 majority of rx_s at counter values point-1, point, point+1.
  - In DATA/PARITY/STOP, "point+1" is counter 0 of the next bit period.
  - Minimum cfg_div_i becomes 4.
- Undefined: a single sample of rx_s at the point.
- Frame timing and outputs are otherwise identical.

Test Plan:
- 8N1 (cfg_div_i=15, cfg_bits_i=11, parity off, 1 stop bit), drive 0xA5 with 16-clock bits, rx_ready_i=1 -> rx_data_o=0xA5, rx_valid_o for 1 cycle, no error pulses, busy_o low after the stop bit.
- 7E1, drive 0x35 with parity bit 1 (correct is 0) -> rx_data_o=0x35, rx_valid_o=1, err_parity_o pulses once in the same cycle; repeat with parity 0 -> no pulse.
- 5N2 (cfg_bits_i=00, cfg_stop_bits_i=1), drive 0x1B with the second stop bit low -> rx_data_o=0x1B, err_frame_o pulse; upper rx_data_o bits read 0.
- rx_ready_i=0, send 0x11 then 0x22 -> rx_data_o stays 0x11, err_overrun_o pulses at the end of the second frame; raising rx_ready_i then clears rx_valid_o.
- Glitch: rx_i low for 3 clocks (cfg_div_i=15) -> false start, busy_o returns to 0, no valid/error; then a full 8N1 frame 0x5A received correctly.
- Deassert cfg_en_i during data bit 3 -> busy_o=0 next cycle, no rx_valid_o/error; re-enable and receive 0xC3 correctly. Assert rstn_i low mid-frame -> all outputs 0 asynchronously.
